// File: rtl/eth_pcs_rx_block_sync_if.sv
// eth_pcs_rx_block_sync_if: header stream from the RX gearbox plus lock/BER status
// towards the descrambler/decoder and management.
interface eth_pcs_rx_block_sync_if #(
    parameter int W_SYNC    = 2,
    parameter int W_ERR_CNT = 8
);
    logic                 i_clk_en;
    logic                 i_hdr_valid;
    logic [W_SYNC-1:0]    i_hdr;
    logic                 i_clr_cnt;
    logic                 o_slip;
    logic                 o_block_lock;
    logic                 o_hi_ber;
    logic                 o_rx_ok;
    logic [W_ERR_CNT-1:0] o_err_cnt;
    modport master (
        output i_clk_en, i_hdr_valid, i_hdr, i_clr_cnt,
        input  o_slip, o_block_lock, o_hi_ber, o_rx_ok, o_err_cnt
    );
    modport slave (
        input  i_clk_en, i_hdr_valid, i_hdr, i_clr_cnt,
        output o_slip, o_block_lock, o_hi_ber, o_rx_ok, o_err_cnt
    );
endinterface

// File: rtl/eth_pcs_rx_block_sync.sv
// eth_pcs_rx_block_sync: 10GBASE-R sync-header block lock, bit-slip request,
// high-BER monitor and saturating invalid-header counter.
module eth_pcs_rx_block_sync #(
    parameter int LOCK_CNT   = 64,
    parameter int BAD_SH_MAX = 16,
    parameter int SLIP_WAIT  = 4,
    parameter int BER_TIMER  = 19531,
    parameter int BER_THRESH = 16,
    parameter int W_ERR_CNT  = 8
) (
    input logic                    i_clk,
    input logic                    i_reset,
    eth_pcs_rx_block_sync_if.slave pcs
);
    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(BAD_SH_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int TW = $clog2(BER_TIMER + 1);
    localparam int CW = $clog2(BER_THRESH + 1);
    localparam logic [SW-1:0] SH_LAST   = SW'(LOCK_CNT);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_SH_MAX);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT);
    localparam logic [TW-1:0] T_LAST    = TW'(BER_TIMER - 1);
    localparam logic [CW-1:0] C_MAX     = CW'(BER_THRESH);

    typedef enum logic [1:0] {S_HUNT, S_LOCKED, S_SLIP_WAIT} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        sh_cnt_q, sh_cnt_d;
    logic [BW-1:0]        bad_cnt_q, bad_cnt_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [TW-1:0]        ber_timer_q, ber_timer_d;
    logic [CW-1:0]        ber_cnt_q, ber_cnt_d;
    logic [W_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
    logic                 slip_q, slip_d, lock_q, lock_d, hi_ber_q, hi_ber_d, rx_ok_q, rx_ok_d;

    logic          hdr_q, hdr_bad, ber_wrap, ber_hit;
    logic [SW-1:0] sh_inc;
    logic [BW-1:0] bad_inc;
    logic [WW-1:0] wait_inc;

    assign hdr_q    = pcs.i_clk_en & pcs.i_hdr_valid;
    assign hdr_bad  = hdr_q & ~^pcs.i_hdr;
    assign sh_inc   = sh_cnt_q + 1'b1;
    assign bad_inc  = bad_cnt_q + BW'(hdr_bad);
    assign wait_inc = wait_cnt_q + 1'b1;
    assign ber_wrap = pcs.i_clk_en & (ber_timer_q == T_LAST);
    assign ber_hit  = hdr_bad & lock_q;

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        if (hdr_q) begin
            case (state_q)
                S_HUNT: begin
                    if (hdr_bad) begin
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        state_d  = S_SLIP_WAIT;
                    end else if (sh_inc == SH_LAST) begin
                        lock_d   = 1'b1;
                        sh_cnt_d = '0;
                        state_d  = S_LOCKED;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
                // loss of lock is tested first so it wins over a same-cycle window end
                S_LOCKED: begin
                    sh_cnt_d  = (bad_inc == BAD_LAST || sh_inc == SH_LAST) ? '0 : sh_inc;
                    bad_cnt_d = (bad_inc == BAD_LAST || sh_inc == SH_LAST) ? '0 : bad_inc;
                    if (bad_inc == BAD_LAST) begin
                        lock_d  = 1'b0;
                        slip_d  = 1'b1;
                        state_d = S_SLIP_WAIT;
                    end
                end
                default: begin
                    wait_cnt_d = (wait_inc == WAIT_LAST) ? '0 : wait_inc;
                    state_d    = (wait_inc == WAIT_LAST) ? S_HUNT : S_SLIP_WAIT;
                end
            endcase
        end
    end

    // errors on the wrap cycle itself open the next BER window
    always_comb begin
        ber_timer_d = !pcs.i_clk_en ? ber_timer_q : ber_wrap ? '0 : ber_timer_q + 1'b1;
        ber_cnt_d   = ber_wrap ? CW'(ber_hit) :
                      (ber_hit && ber_cnt_q != C_MAX) ? ber_cnt_q + 1'b1 : ber_cnt_q;
        hi_ber_d    = ber_wrap ? (ber_cnt_q == C_MAX) : (hi_ber_q || ber_cnt_d == C_MAX);
        err_cnt_d   = (pcs.i_clk_en && pcs.i_clr_cnt) ? '0 :
                      (hdr_bad && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
        rx_ok_d     = lock_d & ~hi_ber_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_HUNT;
            sh_cnt_q    <= '0;
            bad_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            ber_timer_q <= '0;
            ber_cnt_q   <= '0;
            err_cnt_q   <= '0;
            slip_q      <= 1'b0;
            lock_q      <= 1'b0;
            hi_ber_q    <= 1'b0;
            rx_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ber_timer_q <= ber_timer_d;
            ber_cnt_q   <= ber_cnt_d;
            err_cnt_q   <= err_cnt_d;
            slip_q      <= slip_d;
            lock_q      <= lock_d;
            hi_ber_q    <= hi_ber_d;
            rx_ok_q     <= rx_ok_d;
        end
    end

    assign pcs.o_slip       = slip_q;
    assign pcs.o_block_lock = lock_q;
    assign pcs.o_hi_ber     = hi_ber_q;
    assign pcs.o_rx_ok      = rx_ok_q;
    assign pcs.o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// tb_eth_pcs_rx_block_sync: directed header sequences against hand-computed lock,
// slip, BER and error-count expectations (BER window shortened to 100 cycles).
module tb_eth_pcs_rx_block_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   slips = 0;
    int   base;

    eth_pcs_rx_block_sync_if #(.W_SYNC(2), .W_ERR_CNT(8)) pcs ();

    eth_pcs_rx_block_sync #(
        .LOCK_CNT(64), .BAD_SH_MAX(16), .SLIP_WAIT(4),
        .BER_TIMER(100), .BER_THRESH(16), .W_ERR_CNT(8)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .pcs    (pcs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] h, input logic v = 1'b1, input logic clr = 1'b0);
        pcs.i_clk_en    = 1'b1;
        pcs.i_hdr_valid = v;
        pcs.i_hdr       = h;
        pcs.i_clr_cnt   = clr;
        @(posedge clk);
        #1;
        slips += int'(pcs.o_slip);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        pcs.i_clk_en    = 1'b0;
        pcs.i_hdr_valid = 1'b0;
        pcs.i_hdr       = 2'b00;
        pcs.i_clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ber_run(input int last);
        for (int n = 1; n <= last; n++) begin
            send(((n >= 101 && n <= 115) || n == 129) ? 2'b11 : 2'b01);
            if (n == 64) check("ber_lock", int'(pcs.o_block_lock), 1);
            if (n == 128) check("ber_below_thresh", int'(pcs.o_hi_ber), 0);
            if (n == 129) begin
                check("ber_hi_set", int'(pcs.o_hi_ber), 1);
                check("ber_rx_ok_low", int'(pcs.o_rx_ok), 0);
                check("ber_lock_held", int'(pcs.o_block_lock), 1);
            end
            if (n == 299) check("ber_hi_held", int'(pcs.o_hi_ber), 1);
            if (n == 300) begin
                check("ber_hi_clear", int'(pcs.o_hi_ber), 0);
                check("ber_rx_ok_back", int'(pcs.o_rx_ok), 1);
            end
        end
    endtask

    initial begin
        // reset state and plain acquisition
        do_reset();
        check("rst_slip", int'(pcs.o_slip), 0);
        check("rst_lock", int'(pcs.o_block_lock), 0);
        check("rst_hi_ber", int'(pcs.o_hi_ber), 0);
        check("rst_rx_ok", int'(pcs.o_rx_ok), 0);
        check("rst_err", int'(pcs.o_err_cnt), 0);
        for (int i = 0; i < 63; i++) send(2'b01);
        check("acq_lock_63", int'(pcs.o_block_lock), 0);
        send(2'b01);
        check("acq_lock_64", int'(pcs.o_block_lock), 1);
        check("acq_rx_ok", int'(pcs.o_rx_ok), 1);
        check("acq_no_slip", slips, 0);
        pcs.i_clk_en = 1'b0; pcs.i_hdr_valid = 1'b1; pcs.i_hdr = 2'b11;
        @(posedge clk);
        #1;
        check("en_low_err", int'(pcs.o_err_cnt), 0);
        check("en_low_lock", int'(pcs.o_block_lock), 1);
        send(2'b11, 1'b0);
        check("hdr_invalid_ignored", int'(pcs.o_err_cnt), 0);

        // slip in hunt, slip-wait, then re-acquisition
        do_reset();
        slips = 0;
        for (int i = 0; i < 9; i++) send(2'b01);
        send(2'b11);
        check("hunt_slip", int'(pcs.o_slip), 1);
        check("hunt_err", int'(pcs.o_err_cnt), 1);
        base = slips;
        for (int i = 0; i < 4; i++) send(2'b11);
        check("wait_slip_low", int'(pcs.o_slip), 0);
        check("wait_err", int'(pcs.o_err_cnt), 5);
        for (int i = 0; i < 63; i++) send(2'b01);
        check("reacq_lock_63", int'(pcs.o_block_lock), 0);
        send(2'b01);
        check("reacq_lock_64", int'(pcs.o_block_lock), 1);
        check("wait_no_slip", slips - base, 0);

        // 15 bad headers per window keep lock; 16th on the window's last header loses it
        send(2'b01, 1'b0, 1'b1);
        check("clr_err", int'(pcs.o_err_cnt), 0);
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++) send(i < 15 ? 2'b11 : 2'b01);
        check("bad15_lock", int'(pcs.o_block_lock), 1);
        check("bad15_err", int'(pcs.o_err_cnt), 45);
        for (int i = 0; i < 63; i++) send(i >= 48 ? 2'b11 : 2'b01);
        check("bad_last_15_lock", int'(pcs.o_block_lock), 1);
        check("bad_last_15_slip", int'(pcs.o_slip), 0);
        send(2'b11);
        check("bad16_lock_lost", int'(pcs.o_block_lock), 0);
        check("bad16_slip", int'(pcs.o_slip), 1);
        check("bad16_err", int'(pcs.o_err_cnt), 61);
        send(2'b01);
        check("slip_one_cycle", int'(pcs.o_slip), 0);

        // BER window behaviour
        do_reset();
        ber_run(300);

        // error counter saturation and clear precedence
        do_reset();
        for (int i = 0; i < 254; i++) send(2'b11);
        check("err_254", int'(pcs.o_err_cnt), 254);
        for (int i = 0; i < 46; i++) send(2'b11);
        check("err_sat", int'(pcs.o_err_cnt), 255);
        send(2'b11, 1'b1, 1'b1);
        check("err_clr_wins", int'(pcs.o_err_cnt), 0);

        // asynchronous reset while locked with high BER
        do_reset();
        ber_run(130);
        #3;
        rst = 1'b1;
        #1;
        check("arst_lock", int'(pcs.o_block_lock), 0);
        check("arst_hi_ber", int'(pcs.o_hi_ber), 0);
        check("arst_rx_ok", int'(pcs.o_rx_ok), 0);
        check("arst_err", int'(pcs.o_err_cnt), 0);
        check("arst_slip", int'(pcs.o_slip), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 63; i++) send(2'b01);
        check("post_rst_lock_63", int'(pcs.o_block_lock), 0);
        send(2'b01);
        check("post_rst_lock_64", int'(pcs.o_block_lock), 1);
        check("post_rst_rx_ok", int'(pcs.o_rx_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
